// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - push/pop/peek sequencer for the parameter and return stacks
// Drives one memory access and one stack-pointer write-back per accepted operation.
module stack_sequencer #(
  parameter logic [15:0] P_BASE  = 16'd48,
  parameter logic [15:0] P_LIMIT = 16'd56,
  parameter logic [15:0] R_BASE  = 16'd56,
  parameter logic [15:0] R_LIMIT = 16'd64
) (
  input  logic        c_CLOCK,
  input  logic        c_RESETn,
  input  logic        i_START,
  input  logic [1:0]  i_OP,
  input  logic        i_SEL,
  input  logic [15:0] i_TOS,
  input  logic [15:0] i_PSP,
  input  logic [15:0] i_RSP,
  output logic        o_MREQ,
  output logic        o_MWE,
  output logic [15:0] o_MADDR,
  output logic [15:0] o_MDATA,
  input  logic        i_MACK,
  input  logic [15:0] i_MDATA,
  output logic [3:0]  o_WADDR,
  output logic [15:0] o_WDATA,
  output logic        o_WRITE,
  output logic [15:0] o_RESULT,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b11;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_sel;
  logic [15:0] r_sp;

  logic [15:0] w_sp;
  logic [15:0] w_base;
  logic [15:0] w_limit;
  logic        w_is_push;
  logic        w_bound_err;
  logic [15:0] w_addr;
  logic [15:0] w_new_sp;

  // Pointers address the next free slot, so reads target SP-1.
  assign w_sp        = i_SEL ? i_RSP : i_PSP;
  assign w_base      = i_SEL ? R_BASE : P_BASE;
  assign w_limit     = i_SEL ? R_LIMIT : P_LIMIT;
  assign w_is_push   = (i_OP == OP_PUSH);
  assign w_bound_err = w_is_push ? (w_sp >= w_limit) : (w_sp <= w_base);
  assign w_addr      = w_is_push ? w_sp : (w_sp - 16'd1);
  assign w_new_sp    = (r_op == OP_PUSH) ? (r_sp + 16'd1) : (r_sp - 16'd1);

  always_ff @(posedge c_CLOCK or negedge c_RESETn) begin
    if (!c_RESETn) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_sel    <= 1'b0;
      r_sp     <= 16'd0;
      o_MREQ   <= 1'b0;
      o_MWE    <= 1'b0;
      o_MADDR  <= 16'd0;
      o_MDATA  <= 16'd0;
      o_WADDR  <= 4'd0;
      o_WDATA  <= 16'd0;
      o_WRITE  <= 1'b0;
      o_RESULT <= 16'd0;
      o_BUSY   <= 1'b0;
      o_DONE   <= 1'b0;
      o_ERR    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_START && (i_OP != OP_NOP)) begin
            r_op   <= i_OP;
            r_sel  <= i_SEL;
            r_sp   <= w_sp;
            o_BUSY <= 1'b1;
            if (w_bound_err) begin
              o_ERR   <= 1'b1;
              o_DONE  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_ERR   <= 1'b0;
              o_MREQ  <= 1'b1;
              o_MWE   <= w_is_push;
              o_MADDR <= w_addr;
              o_MDATA <= i_TOS;
              r_state <= S_MEM;
            end
          end
        end

        S_MEM: begin
          if (i_MACK) begin
            o_MREQ  <= 1'b0;
            o_MWE   <= 1'b0;
            o_MADDR <= 16'd0;
            o_MDATA <= 16'd0;
            if (r_op != OP_PUSH) begin
              o_RESULT <= i_MDATA;
            end
            // PEEK leaves the pointer alone, so it skips write-back.
            if (r_op == OP_PEEK) begin
              o_DONE  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_WRITE <= 1'b1;
              o_WADDR <= r_sel ? 4'd2 : 4'd1;
              o_WDATA <= w_new_sp;
              r_state <= S_WB;
            end
          end
        end

        S_WB: begin
          o_WRITE <= 1'b0;
          o_WADDR <= 4'd0;
          o_WDATA <= 16'd0;
          o_DONE  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          o_DONE  <= 1'b0;
          o_BUSY  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          o_MREQ  <= 1'b0;
          o_MWE   <= 1'b0;
          o_MADDR <= 16'd0;
          o_MDATA <= 16'd0;
          o_WRITE <= 1'b0;
          o_WADDR <= 4'd0;
          o_WDATA <= 16'd0;
          o_DONE  <= 1'b0;
          o_BUSY  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - self-checking bench for stack_sequencer
// Transaction model expands each operation into an expected per-cycle output trace.
module tb_stack_sequencer;

  localparam logic [15:0] P_BASE  = 16'd48;
  localparam logic [15:0] P_LIMIT = 16'd56;
  localparam logic [15:0] R_BASE  = 16'd56;
  localparam logic [15:0] R_LIMIT = 16'd64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_START = 1'b0;
  logic [1:0]  i_OP = 2'b00;
  logic        i_SEL = 1'b0;
  logic [15:0] i_TOS = 16'd0;
  logic [15:0] i_PSP = 16'd0;
  logic [15:0] i_RSP = 16'd0;
  logic        i_MACK = 1'b0;
  logic [15:0] i_MDATA = 16'd0;
  logic        o_MREQ, o_MWE, o_WRITE, o_BUSY, o_DONE, o_ERR;
  logic [15:0] o_MADDR, o_MDATA, o_WDATA, o_RESULT;
  logic [3:0]  o_WADDR;

  always #5 clk = ~clk;

  stack_sequencer #(
    .P_BASE(P_BASE), .P_LIMIT(P_LIMIT), .R_BASE(R_BASE), .R_LIMIT(R_LIMIT)
  ) dut (
    .c_CLOCK(clk), .c_RESETn(rst_n), .i_START(i_START), .i_OP(i_OP),
    .i_SEL(i_SEL), .i_TOS(i_TOS), .i_PSP(i_PSP), .i_RSP(i_RSP),
    .o_MREQ(o_MREQ), .o_MWE(o_MWE), .o_MADDR(o_MADDR), .o_MDATA(o_MDATA),
    .i_MACK(i_MACK), .i_MDATA(i_MDATA), .o_WADDR(o_WADDR), .o_WDATA(o_WDATA),
    .o_WRITE(o_WRITE), .o_RESULT(o_RESULT), .o_BUSY(o_BUSY), .o_DONE(o_DONE),
    .o_ERR(o_ERR)
  );

  typedef struct {
    logic        mreq;
    logic        mwe;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic        write;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_result = 16'd0;
  logic        m_err = 1'b0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  int          mreq_cnt, wr_cnt, done_cnt;
  logic [15:0] last_maddr, last_mdata, last_wdata;
  logic [3:0]  last_waddr;
  logic        last_mwe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t blank_rec();
    exp_t e;
    e.mreq = 1'b0; e.mwe = 1'b0; e.maddr = 16'd0; e.mdata = 16'd0;
    e.write = 1'b0; e.waddr = 4'd0; e.wdata = 16'd0;
    e.busy = 1'b0; e.done = 1'b0; e.err = m_err; e.result = m_result;
    return e;
  endfunction

  task automatic clear_mon();
    mreq_cnt = 0; wr_cnt = 0; done_cnt = 0;
    last_maddr = 16'd0; last_mdata = 16'd0; last_wdata = 16'd0;
    last_waddr = 4'd0; last_mwe = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = blank_rec();
      chk("mreq",   {31'd0, o_MREQ},  {31'd0, e.mreq});
      chk("mwe",    {31'd0, o_MWE},   {31'd0, e.mwe});
      chk("maddr",  {16'd0, o_MADDR}, {16'd0, e.maddr});
      chk("mdata",  {16'd0, o_MDATA}, {16'd0, e.mdata});
      chk("write",  {31'd0, o_WRITE}, {31'd0, e.write});
      chk("waddr",  {28'd0, o_WADDR}, {28'd0, e.waddr});
      chk("wdata",  {16'd0, o_WDATA}, {16'd0, e.wdata});
      chk("busy",   {31'd0, o_BUSY},  {31'd0, e.busy});
      chk("done",   {31'd0, o_DONE},  {31'd0, e.done});
      chk("err",    {31'd0, o_ERR},   {31'd0, e.err});
      chk("result", {16'd0, o_RESULT}, {16'd0, e.result});
      if (o_MREQ) begin
        mreq_cnt++; last_maddr = o_MADDR; last_mdata = o_MDATA; last_mwe = o_MWE;
      end
      if (o_WRITE) begin
        wr_cnt++; last_waddr = o_WADDR; last_wdata = o_WDATA;
      end
      if (o_DONE) done_cnt++;
    end
  end

  // Called at posedge+1; start is sampled by the next rising edge.
  task automatic run_op(input logic [1:0] op, input logic sel, input logic [15:0] tos,
                        input logic [15:0] psp, input logic [15:0] rsp, input int waits,
                        input logic [15:0] rdata, input bit poke_busy);
    exp_t        e;
    logic [15:0] sp, base, limit;
    bit          is_err;
    int          n;
    sp     = sel ? rsp : psp;
    base   = sel ? R_BASE : P_BASE;
    limit  = sel ? R_LIMIT : P_LIMIT;
    is_err = (op == 2'b01) ? (sp >= limit) : (sp <= base);
    clear_mon();
    exp_q.push_back(blank_rec());
    if (is_err) begin
      m_err = 1'b1;
      e = blank_rec(); e.busy = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
    end else begin
      m_err = 1'b0;
      for (int k = 0; k <= waits; k++) begin
        e = blank_rec(); e.busy = 1'b1; e.mreq = 1'b1; e.mwe = (op == 2'b01);
        e.maddr = (op == 2'b01) ? sp : sp - 16'd1;
        e.mdata = tos;
        exp_q.push_back(e);
      end
      if (op != 2'b01) m_result = rdata;
      if (op != 2'b11) begin
        e = blank_rec(); e.busy = 1'b1; e.write = 1'b1;
        e.waddr = sel ? 4'd2 : 4'd1;
        e.wdata = (op == 2'b01) ? sp + 16'd1 : sp - 16'd1;
        exp_q.push_back(e);
      end
      e = blank_rec(); e.busy = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
    end
    i_START = 1'b1; i_OP = op; i_SEL = sel; i_TOS = tos; i_PSP = psp; i_RSP = rsp;
    @(posedge clk); #1;
    i_START = 1'b0; i_OP = 2'b00;
    if (!is_err) begin
      for (int k = 0; k <= waits; k++) begin
        i_MACK  = (k == waits);
        i_MDATA = (k == waits) ? rdata : 16'hDEAD;
        if (poke_busy) begin
          i_START = 1'b1; i_OP = 2'b01; i_SEL = 1'b0; i_PSP = 16'd48; i_TOS = 16'h5555;
        end
        @(posedge clk); #1;
      end
      i_MACK = 1'b0; i_MDATA = 16'd0; i_START = 1'b0; i_OP = 2'b00;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    #12;
    chk("rst_mreq",  {31'd0, o_MREQ},  32'd0);
    chk("rst_busy",  {31'd0, o_BUSY},  32'd0);
    chk("rst_result", {16'd0, o_RESULT}, 32'd0);
    chk("rst_err",   {31'd0, o_ERR},   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Push on the very first edge after reset release, ack one cycle after request.
    run_op(2'b01, 1'b0, 16'hBEEF, 16'd48, 16'd60, 1, 16'd0, 1'b0);
    chk("p22_maddr", {16'd0, last_maddr}, 32'd48);
    chk("p22_mwe",   {31'd0, last_mwe},   32'd1);
    chk("p22_mdata", {16'd0, last_mdata}, 32'hBEEF);
    chk("p22_waddr", {28'd0, last_waddr}, 32'd1);
    chk("p22_wdata", {16'd0, last_wdata}, 32'd49);
    chk("p22_done",  done_cnt, 1);
    chk("p22_err",   {31'd0, o_ERR}, 32'd0);

    run_op(2'b10, 1'b1, 16'h0000, 16'd49, 16'd58, 3, 16'h1234, 1'b0);
    chk("p23_mreq_cycles", mreq_cnt, 4);
    chk("p23_maddr",  {16'd0, last_maddr}, 32'd57);
    chk("p23_result", {16'd0, o_RESULT},  32'h1234);
    chk("p23_waddr",  {28'd0, last_waddr}, 32'd2);
    chk("p23_wdata",  {16'd0, last_wdata}, 32'd57);

    run_op(2'b01, 1'b0, 16'h7777, 16'd56, 16'd60, 0, 16'd0, 1'b0);
    chk("ovf_mreq",  mreq_cnt, 0);
    chk("ovf_write", wr_cnt, 0);
    chk("ovf_err",   {31'd0, o_ERR}, 32'd1);
    run_op(2'b10, 1'b1, 16'h0000, 16'd50, 16'd56, 0, 16'hFFFF, 1'b0);
    chk("unf_mreq",   mreq_cnt, 0);
    chk("unf_write",  wr_cnt, 0);
    chk("unf_err",    {31'd0, o_ERR}, 32'd1);
    chk("unf_result", {16'd0, o_RESULT}, 32'h1234);

    run_op(2'b11, 1'b0, 16'h0000, 16'd50, 16'd60, 0, 16'h00AA, 1'b0);
    chk("peek_maddr",  {16'd0, last_maddr}, 32'd49);
    chk("peek_result", {16'd0, o_RESULT},  32'h00AA);
    chk("peek_write",  wr_cnt, 0);

    run_op(2'b01, 1'b1, 16'hA5A5, 16'd50, 16'd63, 2, 16'd0, 1'b0);
    run_op(2'b01, 1'b1, 16'hA5A5, 16'd50, 16'd64, 0, 16'd0, 1'b0);
    run_op(2'b10, 1'b0, 16'h0000, 16'd49, 16'd60, 0, 16'h4321, 1'b0);
    run_op(2'b11, 1'b1, 16'h0000, 16'd49, 16'd56, 0, 16'h9999, 1'b0);
    run_op(2'b01, 1'b0, 16'h0F0F, 16'd55, 16'd60, 0, 16'd0, 1'b0);

    // Stray acks and NOP starts while idle, then start pulses while busy.
    i_MACK = 1'b1; i_MDATA = 16'hFFFF; i_START = 1'b1; i_OP = 2'b00;
    idle_cycles(3);
    i_MACK = 1'b0; i_MDATA = 16'd0; i_START = 1'b0;
    idle_cycles(1);
    run_op(2'b10, 1'b0, 16'h0000, 16'd52, 16'd60, 2, 16'h0BAD, 1'b1);
    chk("busy_done_cnt", done_cnt, 1);
    idle_cycles(2);

    // Reset in the middle of a memory access.
    chk_en = 1'b0;
    i_START = 1'b1; i_OP = 2'b01; i_SEL = 1'b0; i_PSP = 16'd48; i_TOS = 16'h1111;
    @(posedge clk); #1;
    i_START = 1'b0; i_OP = 2'b00;
    @(posedge clk); #1;
    chk("pre_rst_mreq", {31'd0, o_MREQ}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mreq",   {31'd0, o_MREQ},  32'd0);
    chk("rst_mid_busy",   {31'd0, o_BUSY},  32'd0);
    chk("rst_mid_result", {16'd0, o_RESULT}, 32'd0);
    m_result = 16'd0; m_err = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    chk_en = 1'b1;
    idle_cycles(3);
    chk("rst_no_write", wr_cnt, 0);
    run_op(2'b01, 1'b0, 16'h2222, 16'd48, 16'd60, 0, 16'd0, 1'b0);
    chk("post_rst_wdata", {16'd0, last_wdata}, 32'd49);
    chk("post_rst_done",  done_cnt, 1);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
